// File: rtl/bus_host_arb.sv
// bus_host_arb: arbitrates NumHosts hosts onto one req/gnt/rvalid device port and routes responses back through an in-order ID FIFO.
// Define BUS_HOST_ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority (lowest index wins) otherwise.
module bus_host_arb #(
  parameter int NumHosts       = 2,
  parameter int MaxOutstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumHosts-1:0]      host_req_i,
  input  logic [NumHosts-1:0]      host_we_i,
  input  logic [NumHosts*4-1:0]    host_be_i,
  input  logic [NumHosts*32-1:0]   host_addr_i,
  input  logic [NumHosts*32-1:0]   host_wdata_i,
  output logic [NumHosts-1:0]      host_gnt_o,
  output logic [NumHosts-1:0]      host_rvalid_o,
  output logic [NumHosts-1:0]      host_err_o,
  output logic [31:0]              host_rdata_o,
  output logic                     dev_req_o,
  output logic                     dev_we_o,
  output logic [3:0]               dev_be_o,
  output logic [31:0]              dev_addr_o,
  output logic [31:0]              dev_wdata_o,
  input  logic                     dev_gnt_i,
  input  logic                     dev_rvalid_i,
  input  logic [31:0]              dev_rdata_i,
  input  logic                     dev_err_i
);
  localparam int IdW  = $clog2(NumHosts);
  localparam int PtrW = $clog2(MaxOutstanding) + 1;
  logic [IdW-1:0]  r_ids [MaxOutstanding];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr, r_cnt;
  logic            r_lock;
  logic [IdW-1:0]  r_lock_sel;
  logic [IdW-1:0]  w_arb, w_sel, w_head;
  logic            w_full, w_pop, w_req, w_push;
`ifdef BUS_HOST_ARB_ROUND_ROBIN_EN
  logic [IdW-1:0]  r_rr;
  // Descending scan so the requester closest to the pointer is assigned last and wins.
  always_comb begin
    w_arb = '0;
    for (int k = NumHosts - 1; k >= 0; k--)
      if (host_req_i[(int'(r_rr) + k) % NumHosts]) w_arb = IdW'((int'(r_rr) + k) % NumHosts);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rr <= '0;
    else if (w_push) r_rr <= (int'(w_sel) == NumHosts - 1) ? '0 : w_sel + 1'b1;
  end
`else
  always_comb begin
    w_arb = '0;
    for (int k = NumHosts - 1; k >= 0; k--)
      if (host_req_i[k]) w_arb = IdW'(k);
  end
`endif
  always_comb begin
    w_head = '0;
    for (int k = 0; k < MaxOutstanding; k++)
      if (r_rd_ptr == PtrW'(k)) w_head = r_ids[k];
  end
  assign w_sel  = r_lock ? r_lock_sel : w_arb;
  assign w_full = r_cnt == PtrW'(MaxOutstanding);
  assign w_pop  = rst_ni && dev_rvalid_i && (r_cnt != '0);
  // A response in the same cycle frees a slot, so a full FIFO may still accept a grant.
  assign w_req  = rst_ni && (|host_req_i) && (!w_full || w_pop);
  assign w_push = w_req && dev_gnt_i;
  assign dev_req_o     = w_req;
  assign dev_we_o      = rst_ni && host_we_i[w_sel];
  assign dev_be_o      = rst_ni ? host_be_i[4*w_sel +: 4] : '0;
  assign dev_addr_o    = rst_ni ? host_addr_i[32*w_sel +: 32] : '0;
  assign dev_wdata_o   = rst_ni ? host_wdata_i[32*w_sel +: 32] : '0;
  assign host_gnt_o    = NumHosts'(w_push) << w_sel;
  assign host_rvalid_o = NumHosts'(w_pop) << w_head;
  assign host_err_o    = NumHosts'(w_pop && dev_err_i) << w_head;
  assign host_rdata_o  = rst_ni ? dev_rdata_i : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_lock     <= 1'b0;
      r_lock_sel <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= (r_rd_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_cnt <= r_cnt + PtrW'(w_push) - PtrW'(w_pop);
      if (w_push) r_lock <= 1'b0;
      else if (w_req && !dev_gnt_i) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_sel;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < MaxOutstanding; k++)
      if (w_push && r_wr_ptr == PtrW'(k)) r_ids[k] <= w_sel;
  end
  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (!(dev_rvalid_i && r_cnt == '0)) else $error("bus_host_arb: dev_rvalid_i with no outstanding request");
  end
endmodule

// File: tb/tb_bus_host_arb.sv
// tb_bus_host_arb: directed scoreboard bench for bus_host_arb (NumHosts=2, MaxOutstanding=2).
module tb_bus_host_arb;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  host_req_i = '0, host_we_i = '0;
  logic [7:0]  host_be_i = 8'hF3;
  logic [63:0] host_addr_i = {32'h100, 32'h200};
  logic [63:0] host_wdata_i = {32'hB1, 32'hA0};
  logic [1:0]  host_gnt_o, host_rvalid_o, host_err_o;
  logic [31:0] host_rdata_o, dev_addr_o, dev_wdata_o, dev_rdata_i = '0;
  logic        dev_req_o, dev_we_o, dev_gnt_i = 1'b0, dev_rvalid_i = 1'b0, dev_err_i = 1'b0;
  logic [3:0]  dev_be_o;
  int checks = 0, errors = 0;
  int q[$];

  bus_host_arb dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .host_req_i(host_req_i), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_err_o(host_err_o),
    .host_rdata_o(host_rdata_o), .dev_req_o(dev_req_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_addr_o(dev_addr_o), .dev_wdata_o(dev_wdata_o),
    .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
    .dev_err_i(dev_err_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    host_req_i = '0;
    dev_gnt_i = 1'b0;
    dev_rvalid_i = 1'b0;
    dev_err_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    int h;
    logic [31:0] e;
    h = -1;
    if (q.size() > 0) h = q.pop_front();
    e = (h < 0) ? 32'd0 : (32'd1 << h);
    chk({tag, "_rv"}, 32'(host_rvalid_o), e);
    chk({tag, "_err"}, 32'(host_err_o), dev_err_i ? e : 32'd0);
  endtask

  task automatic gnt_chk(input string tag, input int h);
    chk(tag, 32'(host_gnt_o), 32'd1 << h);
    q.push_back(h);
  endtask

  task automatic rsp(input string tag, input logic err, input logic [31:0] d);
    idle();
    dev_rvalid_i = 1'b1;
    dev_err_i = err;
    dev_rdata_i = d;
    #1;
    pop_chk(tag);
    chk({tag, "_rdata"}, host_rdata_o, d);
    tick();
    idle();
  endtask

  initial begin
    int h;
    host_req_i = 2'b11;
    dev_gnt_i = 1'b1;
    #1;
    chk("rst_req", 32'(dev_req_o), 0);
    chk("rst_gnt", 32'(host_gnt_o), 0);
    chk("rst_addr", dev_addr_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();
    // single host 1 read
    host_req_i = 2'b10;
    dev_gnt_i = 1'b1;
    #1;
    chk("t1_req", 32'(dev_req_o), 1);
    chk("t1_addr", dev_addr_o, 32'h100);
    gnt_chk("t1_gnt", 1);
    tick();
    rsp("t1_rsp", 1'b0, 32'hDEADBEEF);
    // both request, device always grants
    for (int i = 0; i < 4; i++) begin
      host_req_i = 2'b11;
      dev_gnt_i = 1'b1;
      dev_rvalid_i = (i > 0);
      #1;
      if (i > 0) pop_chk("t2_rsp");
`ifdef BUS_HOST_ARB_ROUND_ROBIN_EN
      h = i % 2;
`else
      h = 0;
`endif
      chk("t2_wdata", dev_wdata_o, (h == 1) ? 32'hB1 : 32'hA0);
      gnt_chk("t2_gnt", h);
      tick();
    end
    rsp("t2_last", 1'b0, 32'h5);
    // lock held while the device stalls
    host_req_i = 2'b10;
    #1;
    chk("t3_nognt", 32'(host_gnt_o), 0);
    chk("t3_req", 32'(dev_req_o), 1);
    tick();
    host_req_i = 2'b11;
    #1;
    chk("t3_lock_a", dev_addr_o, 32'h100);
    tick();
    #1;
    chk("t3_lock_b", dev_addr_o, 32'h100);
    tick();
    dev_gnt_i = 1'b1;
    #1;
    gnt_chk("t3_gnt1", 1);
    tick();
    host_req_i = 2'b01;
    #1;
    gnt_chk("t3_gnt0", 0);
    tick();
    // FIFO full: no request until a response frees a slot
    #1;
    chk("t4_full_req", 32'(dev_req_o), 0);
    chk("t4_full_gnt", 32'(host_gnt_o), 0);
    tick();
    dev_rvalid_i = 1'b1;
    #1;
    pop_chk("t4_rsp");
    chk("t4_req", 32'(dev_req_o), 1);
    gnt_chk("t4_gnt", 0);
    tick();
    rsp("t4_d0", 1'b0, 32'h10);
    rsp("t4_d1", 1'b0, 32'h11);
    // interleaved 0,1,0 with error on second response
    host_req_i = 2'b01;
    dev_gnt_i = 1'b1;
    #1;
    gnt_chk("t5_g0", 0);
    tick();
    host_req_i = 2'b10;
    #1;
    gnt_chk("t5_g1", 1);
    tick();
    host_req_i = 2'b01;
    dev_rvalid_i = 1'b1;
    #1;
    pop_chk("t5_r0");
    gnt_chk("t5_g2", 0);
    tick();
    rsp("t5_r1", 1'b1, 32'h21);
    rsp("t5_r2", 1'b0, 32'h22);
    // reset with two outstanding, stray response during reset
    host_req_i = 2'b01;
    dev_gnt_i = 1'b1;
    #1;
    gnt_chk("t6_g0", 0);
    tick();
    host_req_i = 2'b10;
    #1;
    gnt_chk("t6_g1", 1);
    tick();
    idle();
    rst_ni = 1'b0;
    dev_rvalid_i = 1'b1;
    #1;
    q.delete();
    chk("t6_stray_rv", 32'(host_rvalid_o), 0);
    chk("t6_stray_err", 32'(host_err_o), 0);
    tick();
    idle();
    rst_ni = 1'b1;
    host_req_i = 2'b01;
    dev_gnt_i = 1'b1;
    #1;
    gnt_chk("t6_post_g0", 0);
    tick();
    #1;
    gnt_chk("t6_post_g1", 0);
    tick();
    #1;
    chk("t6_post_full", 32'(dev_req_o), 0);
    rsp("t6_d0", 1'b0, 32'h30);
    rsp("t6_d1", 1'b0, 32'h31);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
